// File: rtl/cpu24_mem_responder.sv
// Memory-side responder for the CPU24 request port: one outstanding request, programmable wait.
// Optional per-word even parity with error injection is enabled by defining CPU24_MEM_PARITY_EN.
module cpu24_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAdr,
    input  logic [DATA_WIDTH-1:0] reqWData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [DATA_WIDTH-1:0] rspData,
`ifdef CPU24_MEM_PARITY_EN
    input  logic                  injErr,
`endif
    output logic                  rspErr
);

`ifdef CPU24_MEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  reqReady_q;
    logic                  rspValid_q;
    logic [DATA_WIDTH-1:0] rspData_q;
    logic                  rspErr_q;

    logic [MW-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [MW-1:0] rd_word;
    logic [MW-1:0] wr_word;
    logic          mem_we;
    logic          rd_err;

`ifdef CPU24_MEM_PARITY_EN
    logic inj_q;
    assign wr_word = {(^wdata_q) ^ inj_q, wdata_q};
    assign rd_err  = rd_word[DATA_WIDTH] != (^rd_word[DATA_WIDTH-1:0]);
`else
    assign wr_word = wdata_q;
    assign rd_err  = 1'b0;
`endif

    // The array is touched only on the WAIT->RESP edge, so an aborted write never lands.
    assign mem_we  = (state_q == S_WAIT) && (cnt_q == 4'd0) && wr_q;
    assign rd_word = mem_q[adr_q];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[adr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
`ifdef CPU24_MEM_PARITY_EN
            inj_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reqValid && reqReady_q) begin
                        adr_q      <= reqAdr;
                        wr_q       <= reqWrite;
                        wdata_q    <= reqWData;
`ifdef CPU24_MEM_PARITY_EN
                        inj_q      <= injErr;
`endif
                        cnt_q      <= 4'(WAIT_CYCLES);
                        reqReady_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end else begin
                        reqReady_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= S_RESP;
                        rspValid_q <= 1'b1;
                        if (wr_q) begin
                            rspData_q <= '0;
                            rspErr_q  <= 1'b0;
                        end else begin
                            rspData_q <= rd_word[DATA_WIDTH-1:0];
                            rspErr_q  <= rd_err;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rspReady) begin
                        rspValid_q <= 1'b0;
                        rspData_q  <= '0;
                        rspErr_q   <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reqReady = reqReady_q;
    assign rspValid = rspValid_q;
    assign rspData  = rspData_q;
    assign rspErr   = rspErr_q;

endmodule
